instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have parameter MEM_DEPTH, default 64, giving the number of instruction-memory words (power of two, minimum 2).
REQ-002 The block SHALL have parameter ADDR_W, default 6, giving the address width, with MEM_DEPTH = 2**ADDR_W.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 The ports SHALL be as follows, clock and reset first:
- clk  in  1  rising-edge clock
- rst_n  in  1  async active-low reset
- clear  in  1  sync restart: pointer to 0, abort pending write
- in_valid  in  1  encode request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- in_fmt  in  2  00 load-I, 01 store-S, 10 branch-SB, 11 reserved
- in_rd  in  5  destination register
- in_rs1  in  5  source register 1
- in_rs2  in  5  source register 2
- in_funct3  in  3  funct3 field
- in_imm  in  64  sign-extended immediate
- mem_we  out  1  write strobe to instruction memory
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  encoded instruction
- mem_ready  in  1  memory accepts write when mem_we && mem_ready
- err_valid  out  1  one-cycle error pulse
- err_code  out  2  01 immediate out of range, 10 reserved format
- word_count  out  ADDR_W+1  words written since reset/clear
- full  out  1  word_count == MEM_DEPTH

Function
REQ-005 The FSM SHALL have states IDLE, WRITE and FULL.
REQ-006 in_ready SHALL be 1 only in IDLE with clear low.
REQ-007 On acceptance in cycle N, the block SHALL register the encoded word and present mem_we=1, mem_addr=word_count[ADDR_W-1:0] and mem_wdata in cycle N+1 (state WRITE).
REQ-008 Load-I encoding SHALL be: [31:20]=imm[11:0], [19:15]=rs1, [14:12]=funct3, [11:7]=rd, [6:0]=0000011.
REQ-009 Store-S encoding SHALL be: [31:25]=imm[11:5], [24:20]=rs2, [19:15]=rs1, [14:12]=funct3, [11:7]=imm[4:0], [6:0]=0100011.
REQ-010 Branch-SB encoding SHALL be: [31]=imm[11], [30:25]=imm[9:4], [24:20]=rs2, [19:15]=rs1, [14:12]=funct3, [11:8]=imm[3:0], [7]=imm[10], [6:0]=1100111, exactly inverting the core's immediate generator.
REQ-011 The range check SHALL fail unless in_imm[63:11] are all equal to in_imm[11].
REQ-012 On a range failure, the block SHALL pulse err_valid in N+1 with err_code=01, stay in IDLE, perform no write, and leave word_count unchanged.
REQ-013 in_fmt=11 SHALL be handled the same as REQ-012 but with err_code=10; a reserved format takes priority over a range failure.
REQ-014 In WRITE, mem_we, mem_addr and mem_wdata SHALL hold stable until mem_ready=1.
REQ-015 On a completed write, word_count SHALL increment and the FSM SHALL go to FULL if the new count equals MEM_DEPTH, else to IDLE.
REQ-016 In FULL, in_ready SHALL be 0 and full SHALL be 1; only clear or reset exits FULL.
REQ-017 clear=1 in any state SHALL, at the next edge, set word_count=0, drop mem_we and enter IDLE; an incomplete pending write is discarded.
REQ-018 clear and in_valid high together SHALL mean no acceptance.
REQ-019 clear asserted in the same cycle mem_ready completes a write SHALL leave the write completed at memory while word_count still goes to 0.
REQ-020 Back-to-back throughput SHALL be one word per 2 cycles when mem_ready is held high.

Reset
REQ-021 rst_n=0 SHALL immediately force state IDLE, mem_we=0, mem_addr=0, mem_wdata=0, err_valid=0, err_code=0, word_count=0 and full=0, regardless of the clock.
REQ-022 During reset, in_ready SHALL be 0.
REQ-023 After reset deassertion, in_ready SHALL be 1 on the first clock edge.
REQ-024 Reset during WRITE SHALL abandon the write with no further mem_we.

Verification
REQ-025 Load: fmt=00, rd=5, rs1=2, funct3=3, imm=8 -> next cycle mem_we=1, mem_addr=0, mem_wdata=0x00813283; word_count=1 after mem_ready.
REQ-026 Store: fmt=01, rs2=6, rs1=2, funct3=3, imm=-8 -> mem_wdata=0xFE613C23.
REQ-027 Branch: fmt=10, rs1=1, rs2=2, funct3=0, imm=16 -> mem_wdata=0x02208067; decoding it with the core's immediate generator returns 16.
REQ-028 Error: imm=0x800 -> err_valid one cycle, err_code=01, no mem_we, word_count unchanged; fmt=11 -> err_code=10.
REQ-029 Backpressure/full: MEM_DEPTH=4, mem_ready low 3 cycles -> outputs stable; after 4 writes full=1 and in_ready=0; clear -> word_count=0, next write at addr 0.
REQ-030 Async reset mid-WRITE with mem_ready=0 -> mem_we=0 before the next edge, word_count=0, no write observed.

Source files
------------

// File: rtl/instr_encoder.sv
// Encodes load/store/branch requests into 32-bit instruction words and writes
// them sequentially into an instruction memory, with range/format error reporting.
module instr_encoder #(
    parameter int MEM_DEPTH = 64,
    parameter int ADDR_W    = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_fmt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [63:0]       in_imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    output logic              err_valid,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   word_count,
    output logic              full
);

    typedef enum logic [1:0] {IDLE, WRITE, FULL} state_t;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(MEM_DEPTH);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              err_valid_q, err_valid_d;
    logic [1:0]        err_code_q, err_code_d;
    logic [ADDR_W:0]   count_q, count_d;

    logic              accept;
    logic              imm_ok;
    logic [ADDR_W:0]   count_inc;
    logic [31:0]       enc;

    // Gated by rst_n so the handshake is dead while reset is held.
    assign in_ready  = rst_n && !clear && (state_q == IDLE);
    assign accept    = in_valid && in_ready;
    assign imm_ok    = (in_imm[63:11] == {53{in_imm[11]}});
    assign count_inc = count_q + 1'b1;

    always_comb begin
        enc = 32'h0;
        case (in_fmt)
            2'b00: enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0000011};
            2'b01: enc = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'b0100011};
            // Bit placement is the exact inverse of the core's SB immediate generator.
            2'b10: enc = {in_imm[11], in_imm[9:4], in_rs2, in_rs1, in_funct3,
                          in_imm[3:0], in_imm[10], 7'b1100111};
            default: enc = 32'h0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        count_d     = count_q;
        err_valid_d = 1'b0;
        err_code_d  = 2'b00;
        if (clear) begin
            state_d = IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (in_fmt == 2'b11) begin
                            err_valid_d = 1'b1;
                            err_code_d  = 2'b10;
                        end else if (!imm_ok) begin
                            err_valid_d = 1'b1;
                            err_code_d  = 2'b01;
                        end else begin
                            state_d = WRITE;
                            addr_d  = count_q[ADDR_W-1:0];
                            wdata_d = enc;
                        end
                    end
                end
                WRITE: begin
                    if (mem_ready) begin
                        count_d = count_inc;
                        state_d = (count_inc == DEPTH_C) ? FULL : IDLE;
                    end
                end
                FULL:    state_d = FULL;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            err_valid_q <= 1'b0;
            err_code_q  <= 2'b00;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
            count_q     <= count_d;
        end
    end

    assign mem_we     = (state_q == WRITE);
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign err_valid  = err_valid_q;
    assign err_code   = err_code_q;
    assign word_count = count_q;
    assign full       = (count_q == DEPTH_C);

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: driver feeds a field-level reference model,
// a negedge monitor compares every memory write and error pulse against it.
module tb_instr_encoder;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clear = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [1:0]        in_fmt = '0;
    logic [4:0]        in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [2:0]        in_funct3 = '0;
    logic [63:0]       in_imm = '0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ready = 1'b0;
    logic              err_valid;
    logic [1:0]        err_code;
    logic [ADDR_W:0]   word_count;
    logic              full;

    instr_encoder #(.MEM_DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_imm(in_imm),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .err_valid(err_valid), .err_code(err_code),
        .word_count(word_count), .full(full)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit                is_err;
        logic [1:0]        code;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        logic [1:0]        fmt;
        longint            imm;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    bit          m_pending = 0;
    int          m_count   = 0;
    bit          m_rdy     = 0;
    bit          d_use_exp = 0;
    logic [31:0] d_exp     = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic bit in_range(input logic [63:0] v);
        longint s;
        s = longint'(v);
        return (s >= -2048) && (s <= 2047);
    endfunction

    function automatic logic [31:0] model_word(input logic [1:0] fmt, input logic [4:0] rd,
                                               input logic [4:0] rs1, input logic [4:0] rs2,
                                               input logic [2:0] f3, input logic [63:0] imm);
        int unsigned i12, r1, r2, d, f;
        i12 = int'(imm) & 32'hFFF;
        r1 = rs1; r2 = rs2; d = rd; f = f3;
        case (fmt)
            2'b00: return (i12 << 20) | (r1 << 15) | (f << 12) | (d << 7) | 32'h03;
            2'b01: return ((i12 >> 5) << 25) | (r2 << 20) | (r1 << 15) | (f << 12)
                          | ((i12 & 31) << 7) | 32'h23;
            default: return (((i12 >> 11) & 1) << 31) | (((i12 >> 4) & 63) << 25) | (r2 << 20)
                            | (r1 << 15) | (f << 12) | ((i12 & 15) << 8)
                            | (((i12 >> 10) & 1) << 7) | 32'h67;
        endcase
    endfunction

    // The core's SB immediate generator, used to confirm the encoding round-trips.
    function automatic longint core_sb_imm(input logic [31:0] w);
        logic [11:0] i;
        i = {w[31], w[7], w[30:25], w[11:8]};
        return longint'($signed(i));
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (err_valid) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL spurious_err: got err_code %0d expected no event", err_code);
                end else begin
                    exp_t it;
                    it = sb.pop_front();
                    chk("evt_is_err", 64'(!it.is_err), 64'(0));
                    chk("err_code", 64'(err_code), 64'(it.code));
                end
            end
            if (mem_we) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL spurious_write: got addr %0d data %0h expected no write", mem_addr, mem_wdata);
                end else begin
                    exp_t it;
                    it = sb[0];
                    chk("evt_is_write", 64'(it.is_err), 64'(0));
                    chk("mem_addr", 64'(mem_addr), 64'(it.addr));
                    chk("mem_wdata", 64'(mem_wdata), 64'(it.data));
                    if (mem_ready) begin
                        void'(sb.pop_front());
                        if (it.fmt == 2'b10)
                            chk("sb_roundtrip", 64'(core_sb_imm(mem_wdata)), 64'(it.imm));
                    end
                end
            end
        end
    end

    task automatic run_cycle();
        m_rdy = !m_pending && (m_count < DEPTH) && !clear;
        #1;
        chk("in_ready", 64'(in_ready), 64'(m_rdy));
        chk("word_count", 64'(word_count), 64'(m_count));
        chk("full", 64'(full), 64'(m_count == DEPTH));
        @(posedge clk);
        #1;
        if (clear) begin
            if (m_pending && !mem_ready) sb.delete();
            m_pending = 0;
            m_count   = 0;
        end else if (m_pending) begin
            if (mem_ready) begin
                m_count++;
                m_pending = 0;
            end
        end else if (in_valid && m_rdy) begin
            exp_t it;
            it.fmt  = in_fmt;
            it.imm  = longint'(in_imm);
            it.addr = ADDR_W'(m_count % DEPTH);
            it.data = '0;
            it.code = 2'b00;
            it.is_err = 1;
            if (in_fmt == 2'b11) it.code = 2'b10;
            else if (!in_range(in_imm)) it.code = 2'b01;
            else begin
                it.is_err = 0;
                it.data = d_use_exp ? d_exp : model_word(in_fmt, in_rd, in_rs1, in_rs2, in_funct3, in_imm);
                m_pending = 1;
            end
            sb.push_back(it);
        end
        d_use_exp = 0;
    endtask

    task automatic req(input bit v, input logic [1:0] fmt, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                       input longint imm, input bit use_exp, input logic [31:0] exp, input bit mr);
        in_valid = v; in_fmt = fmt; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_imm = imm; d_use_exp = use_exp; d_exp = exp; mem_ready = mr;
    endtask

    task automatic idle(input int n, input bit mr);
        for (int i = 0; i < n; i++) begin
            req(0, 0, 0, 0, 0, 0, 0, 0, 0, mr);
            run_cycle();
        end
    endtask

    initial begin
        #12;
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_mem_we", 64'(mem_we), 64'(0));
        chk("rst_mem_addr", 64'(mem_addr), 64'(0));
        chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
        chk("rst_err_valid", 64'(err_valid), 64'(0));
        chk("rst_err_code", 64'(err_code), 64'(0));
        chk("rst_word_count", 64'(word_count), 64'(0));
        chk("rst_full", 64'(full), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed encodings and errors
        req(1, 2'b00, 5, 2, 0, 3, 8, 1, 32'h00813283, 1);        run_cycle(); idle(1, 1);
        req(1, 2'b01, 0, 2, 6, 3, -8, 1, 32'hFE613C23, 1);       run_cycle(); idle(1, 1);
        req(1, 2'b10, 0, 1, 2, 0, 16, 1, 32'h02208067, 1);       run_cycle(); idle(1, 1);
        req(1, 2'b00, 1, 1, 1, 0, 64'h800, 0, 0, 1);             run_cycle(); idle(1, 1);
        req(1, 2'b11, 1, 1, 1, 0, 4, 0, 0, 1);                   run_cycle(); idle(1, 1);
        req(1, 2'b11, 1, 1, 1, 0, 64'h800, 0, 0, 1);             run_cycle(); idle(1, 1);

        // Restart, then backpressure for three cycles and fill the memory
        clear = 1; idle(1, 1); clear = 0;
        req(1, 2'b01, 0, 7, 9, 2, -2048, 0, 0, 0);               run_cycle();
        idle(3, 0);
        idle(1, 1);
        for (int i = 0; i < 3; i++) begin
            req(1, 2'(i % 3), 3, 4, 5, 1, 2047 - i, 0, 0, 1);    run_cycle();
        end
        for (int i = 0; i < 6; i++) begin
            req(1, 2'b00, 3, 4, 5, 1, 1, 0, 0, 1);               run_cycle();
        end
        clear = 1; idle(1, 1); clear = 0;
        req(1, 2'b00, 9, 8, 7, 6, -1, 0, 0, 1);                  run_cycle(); idle(1, 1);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            longint imm;
            case ($urandom_range(7))
                0, 1, 2, 3: imm = longint'($urandom_range(4095)) - 2048;
                4:          imm = 2047;
                5:          imm = -2048;
                6:          imm = ($urandom_range(1) != 0) ? 2048 : -2049;
                default:    imm = longint'({$urandom, $urandom});
            endcase
            req($urandom_range(2) != 0, 2'($urandom_range(3)), 5'($urandom), 5'($urandom),
                5'($urandom), 3'($urandom), imm, 0, 0, $urandom_range(2) != 0);
            clear = ($urandom_range(19) == 0);
            run_cycle();
        end
        clear = 0;
        idle(2, 1);

        // Asynchronous reset in the middle of a stalled write
        req(1, 2'b00, 1, 2, 3, 4, 100, 0, 0, 0);                 run_cycle();
        req(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_mem_we", 64'(mem_we), 64'(0));
        chk("rst_mid_word_count", 64'(word_count), 64'(0));
        chk("rst_mid_in_ready", 64'(in_ready), 64'(0));
        chk("rst_mid_mem_addr", 64'(mem_addr), 64'(0));
        sb.delete();
        m_pending = 0;
        m_count   = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(4, 1);

        chk("sb_empty", 64'(sb.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
